// File: rtl/aoi222_arc_walker_if.sv
// ============================================================================
// aoi222_arc_walker_if : control, status and cell-stimulus bundle for the walker
// Revision 1.0
// ============================================================================
`default_nettype none

interface aoi222_arc_walker_if;
  logic       start;
  logic       abort;
  logic       zn;
  logic       a1, a2, b1, b2, c1, c2;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_cnt;
  logic [5:0] arc_idx;
  logic [5:0] fail_arc;
  logic [1:0] fail_ph;

  // master: the controller that requests walks and observes the result
  modport master (
    output start, abort, zn,
    input  a1, a2, b1, b2, c1, c2, busy, done, pass, err_cnt, arc_idx, fail_arc, fail_ph
  );

  // slave: the arc walker itself
  modport slave (
    input  start, abort, zn,
    output a1, a2, b1, b2, c1, c2, busy, done, pass, err_cnt, arc_idx, fail_arc, fail_ph
  );
endinterface

`default_nettype wire

// File: rtl/aoi222_arc_walker.sv
// ============================================================================
// aoi222_arc_walker : walks all 54 timing arcs of an AOI222 cell, checks ZN
// Revision 1.0
// ============================================================================
`default_nettype none

module aoi222_arc_walker #(
  parameter int SETTLE = 2
) (
  input  wire logic             ck,
  input  wire logic             rst,
  aoi222_arc_walker_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_RISE  = 3'd2,
    S_FALL  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] C_SETTLE   = 4'(SETTLE);
  localparam logic [5:0] C_LAST_ARC = 6'd53;

  state_t     state;
  logic [3:0] phase_cnt;
  logic [2:0] pin;
  logic [1:0] k1, k2;
  logic [5:0] pins;
  logic       busy, done, pass;
  logic [7:0] err_cnt;
  logic [5:0] arc_idx, fail_arc;
  logic [1:0] fail_ph;

  logic [2:0] next_pin;
  logic [1:0] next_k1, next_k2;
  logic       sample, expected, mismatch;
  logic [7:0] err_next;
  logic [1:0] cur_ph;

  // k selects a side-pair drive of (0,0), (0,1) or (1,0); never (1,1)
  function automatic logic [1:0] side_pair(input logic [1:0] k);
    return {k == 2'd2, k == 2'd1};
  endfunction

  // Pin vector {A1,A2,B1,B2,C1,C2} for a given active pin and its value
  function automatic logic [5:0] pattern(input logic [2:0] p, input logic [1:0] ka,
                                         input logic [1:0] kb, input logic act);
    logic [1:0] own, first, second;
    logic [5:0] v;
    own    = p[0] ? {1'b1, act} : {act, 1'b1};
    first  = side_pair(ka);
    second = side_pair(kb);
    case (p[2:1])
      2'd0:    v = {own, first, second};
      2'd1:    v = {first, own, second};
      default: v = {first, second, own};
    endcase
    return v;
  endfunction

  always_comb begin
    next_pin = pin;
    next_k1  = k1;
    next_k2  = k2;
    if (k2 == 2'd2) begin
      next_k2 = 2'd0;
      if (k1 == 2'd2) begin
        next_k1  = 2'd0;
        next_pin = pin + 3'd1;
      end else begin
        next_k1 = k1 + 2'd1;
      end
    end else begin
      next_k2 = k2 + 2'd1;
    end
  end

  always_comb begin
    sample   = (phase_cnt == C_SETTLE);
    expected = (state != S_RISE);
    // case inequality so an unknown ZN is treated as a mismatch
    mismatch = sample && (bus.zn !== expected);
    err_next = err_cnt + {7'd0, mismatch};
    case (state)
      S_RISE:  cur_ph = 2'd1;
      S_FALL:  cur_ph = 2'd2;
      default: cur_ph = 2'd0;
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state     <= S_IDLE;
      phase_cnt <= 4'd0;
      pin       <= 3'd0;
      k1        <= 2'd0;
      k2        <= 2'd0;
      pins      <= 6'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= 8'd0;
      arc_idx   <= 6'd0;
      fail_arc  <= 6'd0;
      fail_ph   <= 2'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            state     <= S_SETUP;
            busy      <= 1'b1;
            phase_cnt <= 4'd0;
            pin       <= 3'd0;
            k1        <= 2'd0;
            k2        <= 2'd0;
            pins      <= pattern(3'd0, 2'd0, 2'd0, 1'b0);
            pass      <= 1'b0;
            err_cnt   <= 8'd0;
            arc_idx   <= 6'd0;
            fail_arc  <= 6'd0;
            fail_ph   <= 2'd0;
          end
        end
        S_SETUP, S_RISE, S_FALL: begin
          if (bus.abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            pins  <= 6'd0;
          end else if (sample) begin
            err_cnt   <= err_next;
            phase_cnt <= 4'd0;
            if (mismatch && err_cnt == 8'd0) begin
              fail_arc <= arc_idx;
              fail_ph  <= cur_ph;
            end
            case (state)
              S_SETUP: begin
                state <= S_RISE;
                pins  <= pattern(pin, k1, k2, 1'b1);
              end
              S_RISE: begin
                state <= S_FALL;
                pins  <= pattern(pin, k1, k2, 1'b0);
              end
              default: begin
                if (arc_idx == C_LAST_ARC) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_next == 8'd0);
                  pins  <= 6'd0;
                end else begin
                  state   <= S_SETUP;
                  arc_idx <= arc_idx + 6'd1;
                  pin     <= next_pin;
                  k1      <= next_k1;
                  k2      <= next_k2;
                  pins    <= pattern(next_pin, next_k1, next_k2, 1'b0);
                end
              end
            endcase
          end else begin
            phase_cnt <= phase_cnt + 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign {bus.a1, bus.a2, bus.b1, bus.b2, bus.c1, bus.c2} = pins;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.pass     = pass;
  assign bus.err_cnt  = err_cnt;
  assign bus.arc_idx  = arc_idx;
  assign bus.fail_arc = fail_arc;
  assign bus.fail_ph  = fail_ph;

endmodule

`default_nettype wire

// File: tb/tb_aoi222_arc_walker.sv
// ============================================================================
// tb_aoi222_arc_walker : directed self-checking bench for aoi222_arc_walker
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_aoi222_arc_walker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   mode = 0;   // 0 ideal cell, 1 ZN stuck at 0, 2 C1&C2 term missing
  int   checks = 0;
  int   errors = 0;

  aoi222_arc_walker_if bus ();

  aoi222_arc_walker #(.SETTLE(2)) dut (
    .ck  (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  wire [5:0] pins = {bus.a1, bus.a2, bus.b1, bus.b2, bus.c1, bus.c2};

  always_comb begin
    case (mode)
      0:       bus.zn = ~((bus.a1 & bus.a2) | (bus.b1 & bus.b2) | (bus.c1 & bus.c2));
      1:       bus.zn = 1'b0;
      default: bus.zn = ~((bus.a1 & bus.a2) | (bus.b1 & bus.b2));
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_pass"}, 32'(bus.pass), 0);
    chk({tag, "_err"},  32'(bus.err_cnt), 0);
    chk({tag, "_arc"},  32'(bus.arc_idx), 0);
    chk({tag, "_pins"}, 32'(pins), 0);
    chk({tag, "_farc"}, 32'(bus.fail_arc), 0);
    chk({tag, "_fph"},  32'(bus.fail_ph), 0);
  endtask

  // Pulses START, then counts BUSY cycles and DONE pulses until a few cycles past DONE
  task automatic walk(input int restart_at, output int busy_n, output int done_n,
                      output logic [5:0] p0, output logic [5:0] p44);
    int after;
    bit seen;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    p0 = pins;
    p44 = 6'h3f;
    busy_n = 0;
    done_n = 0;
    after = 0;
    seen = 1'b0;
    for (int i = 0; i < 1200 && after < 4; i++) begin
      if (bus.busy) busy_n++;
      if (bus.done) done_n++;
      if (done_n > 0) after++;
      if (!seen && bus.arc_idx == 6'd44) begin
        seen = 1'b1;
        p44 = pins;
      end
      bus.start = (busy_n == restart_at);
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  initial begin
    int busy_n, done_n, err_snap;
    logic [5:0] p0, p44;

    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Ideal cell: full clean walk
    mode = 0;
    walk(-1, busy_n, done_n, p0, p44);
    chk("ideal_arc0_pins", 32'(p0), 32'b010000);
    chk("ideal_arc44_pins", 32'(p44), 32'b101001);
    chk("ideal_busy_len", busy_n, 486);
    chk("ideal_done_cnt", done_n, 1);
    chk("ideal_err", 32'(bus.err_cnt), 0);
    chk("ideal_pass", 32'(bus.pass), 1);
    chk("ideal_idle_pins", 32'(pins), 0);
    chk("ideal_arc_hold", 32'(bus.arc_idx), 53);

    // ZN stuck at 0: SETUP and FALL of every arc fail
    mode = 1;
    walk(-1, busy_n, done_n, p0, p44);
    chk("stuck0_busy_len", busy_n, 486);
    chk("stuck0_err", 32'(bus.err_cnt), 108);
    chk("stuck0_farc", 32'(bus.fail_arc), 0);
    chk("stuck0_fph", 32'(bus.fail_ph), 0);
    chk("stuck0_pass", 32'(bus.pass), 0);
    chk("stuck0_done_cnt", done_n, 1);

    // Missing C1&C2 term: RISE of arcs 36..53 fails
    mode = 2;
    walk(-1, busy_n, done_n, p0, p44);
    chk("noc_err", 32'(bus.err_cnt), 18);
    chk("noc_farc", 32'(bus.fail_arc), 36);
    chk("noc_fph", 32'(bus.fail_ph), 1);
    chk("noc_pass", 32'(bus.pass), 0);

    // ABORT at BUSY cycle 100 with ZN stuck at 0 (22 errors accumulated by then)
    mode = 1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    busy_n = 1;
    for (int i = 0; i < 200 && busy_n < 100; i++) begin
      @(negedge clk);
      if (bus.busy) busy_n++;
    end
    chk("abort_busy_before", 32'(bus.busy), 1);
    err_snap = 32'(bus.err_cnt);
    chk("abort_err_at_100", err_snap, 22);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_pins", 32'(pins), 0);
    chk("abort_err_hold", 32'(bus.err_cnt), 22);
    done_n = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.done) done_n++;
      @(negedge clk);
    end
    chk("abort_no_done", done_n, 0);
    chk("abort_pass", 32'(bus.pass), 0);
    chk("abort_still_idle", 32'(bus.busy), 0);

    // Restart after abort begins from arc 0 with a cleared count
    mode = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("restart_busy", 32'(bus.busy), 1);
    chk("restart_arc", 32'(bus.arc_idx), 0);
    chk("restart_err", 32'(bus.err_cnt), 0);
    chk("restart_pins", 32'(pins), 32'b010000);

    // RST mid-walk with ZN stuck so counters are non-zero
    mode = 1;
    repeat (40) @(negedge clk);
    chk("prereset_err_nonzero", 32'(bus.err_cnt != 8'd0), 1);
    rst = 1'b1;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk_idle_outputs("midreset");

    // START pulsed again during BUSY must not restart the walk
    mode = 0;
    walk(50, busy_n, done_n, p0, p44);
    chk("restart_ignored_len", busy_n, 486);
    chk("restart_ignored_done", done_n, 1);
    chk("restart_ignored_pass", 32'(bus.pass), 1);

    // START with ABORT in IDLE stays idle and leaves PASS alone
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("startabort_busy", 32'(bus.busy), 0);
    chk("startabort_pins", 32'(pins), 0);
    @(negedge clk);
    chk("startabort_busy2", 32'(bus.busy), 0);
    chk("startabort_pass_hold", 32'(bus.pass), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/aoi222_arc_walker.md
AOI222_ARC_WALKER -- requirements
Module: aoi222_arc_walker

Interface
REQ-001 The block SHALL have parameter SETTLE, default 2, giving the number of wait cycles between driving a vector and sampling ZN (legal range 1..15).
REQ-002 CK  input  1  clock; every register SHALL update on the rising edge.
REQ-003 RST  input  1  reset; it SHALL be synchronous and active-high.
REQ-004 START  input  1  one-cycle request to begin a full arc walk.
REQ-005 ABORT  input  1  one-cycle request to stop the walk in progress.
REQ-006 ZN  input  1  output of the AOI222 under test.
REQ-007 A1, A2, B1, B2, C1, C2  output  1 each  registered stimulus to the cell under test.
REQ-008 BUSY  output  1  high while a walk is in progress.
REQ-009 DONE  output  1  one-cycle pulse when a walk completes.
REQ-010 PASS  output  1  level; high when the last completed walk had ERR_CNT==0.
REQ-011 ERR_CNT  output  8  count of mismatches in the current or last walk.
REQ-012 ARC_IDX  output  6  index of the arc currently being exercised, 0..53.
REQ-013 FAIL_ARC  output  6, FAIL_PH  output  2  arc and phase of the first mismatch; valid only when ERR_CNT!=0.

Function
REQ-014 The walk SHALL cover 54 arcs, arc = 9*pin + cond.
  - pin order: A1, A2, B1, B2, C1, C2 = 0..5.
  - The partner pin in the same pair SHALL be held at 1.
  - The two other pairs SHALL be taken in alphabetical order as first/second.
  - cond = 3*k1 + k2.
  - k=0,1,2 SHALL drive the pair as (0,0), (0,1), (1,0).
REQ-015 States SHALL be IDLE, SETUP, RISE, FALL, DONE.
  - Each of SETUP, RISE and FALL SHALL last SETTLE+1 cycles.
  - The phase counter SHALL run 0..SETTLE.
  - ZN SHALL be sampled when the counter equals SETTLE.
REQ-016 The phases SHALL drive the active pin and expect ZN as follows:
  - SETUP (FAIL_PH=0): active pin 0, side pins per REQ-014, expected ZN=1.
  - RISE (FAIL_PH=1): active pin 1, expected ZN=0.
  - FALL (FAIL_PH=2): active pin 0, expected ZN=1.
REQ-017 After FALL of arc 53 the block SHALL enter DONE for one cycle, then return to IDLE.
  - After FALL of any other arc it SHALL enter SETUP of arc+1.
REQ-018 Total walk length SHALL be 54*3*(SETTLE+1) cycles of BUSY=1; this is 486 cycles for SETTLE=2.
REQ-019 A sampled ZN different from the expected value SHALL increment ERR_CNT. Any non-0/1 value SHALL count as a mismatch. The maximum count is 162, so no saturation is required.
REQ-020 On the first mismatch of a walk, FAIL_ARC and FAIL_PH SHALL capture the current arc and phase. Later mismatches SHALL NOT overwrite them.
REQ-021 START in IDLE SHALL take effect as follows:
  - ERR_CNT, FAIL_ARC, FAIL_PH and PASS SHALL clear.
  - ARC_IDX SHALL be set to 0.
  - SETUP SHALL be entered on the next cycle.
REQ-022 START while BUSY SHALL be ignored.
REQ-023 ABORT while BUSY SHALL end the walk as follows:
  - The block SHALL return to IDLE on the next cycle.
  - All six pins SHALL be driven 0.
  - No DONE SHALL be generated; PASS SHALL stay 0.
  - ERR_CNT SHALL hold.
REQ-024 START and ABORT in the same cycle SHALL resolve to ABORT.
REQ-025 DONE and PASS SHALL update in the same cycle. PASS SHALL hold until the next START or RST.
REQ-026 In IDLE all six pins SHALL be 0 and ARC_IDX SHALL hold its last value.

Reset
REQ-027 When RST=1 the block SHALL enter IDLE on the next edge with all outputs 0, regardless of state, including mid-walk.
REQ-028 RST SHALL take priority over START and ABORT.

Verification
REQ-029 Ideal AOI222 model on ZN, SETTLE=2, START pulse -> BUSY high 486 cycles, single DONE pulse, ERR_CNT=0, PASS=1.
REQ-030 ZN tied 0 -> ERR_CNT=108, FAIL_ARC=0, FAIL_PH=0, PASS=0.
REQ-031 Model with the C1&C2 term removed -> ERR_CNT=18 (arcs 36..53, RISE phase), FAIL_ARC=36, FAIL_PH=1.
REQ-032 ABORT at BUSY cycle 100 -> next cycle BUSY=0 and pins=000000, no DONE. A new START then restarts at ARC_IDX=0 with ERR_CNT=0.
REQ-033 RST mid-walk -> next cycle all outputs 0. START pulsed during BUSY is ignored, and the walk still lasts 486 cycles. START+ABORT in IDLE -> stays IDLE.
REQ-034 Arc 0 SETUP SHALL drive A1..C2 = 0,1,0,0,0,0. Arc 44 (C1, cond 8) SETUP SHALL drive A1..C2 = 1,0,1,0,0,1.
